// File: rtl/split_check_sequencer.sv
// Steps a candidate assignment through NUM_SPLITS split-constraint checks via an external
// result mux, reports pass/fail with the lowest failing index, and keeps saturating statistics.
module split_check_sequencer #(
    parameter int NUM_SPLITS = 8,
    parameter int SEL_W      = 3,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic             flush,
    output logic [SEL_W-1:0] split_sel,
    input  logic             split_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [SEL_W-1:0] res_fail_idx,
    output logic [SEL_W:0]   res_fail_cnt,
    output logic             busy,
    output logic [CNT_W-1:0] stat_pass,
    output logic [CNT_W-1:0] stat_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SPLITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state, state_next;
    logic [SEL_W-1:0] sel_q, sel_next;
    logic [SEL_W-1:0] fail_idx_q, fail_idx_next;
    logic [SEL_W:0]   fail_cnt_q, fail_cnt_next;
    logic             ready_q;
    logic             handoff;
    logic             result_pass;
    logic [CNT_W-1:0] pass_q, fail_q;

    assign result_pass = (fail_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        sel_next      = sel_q;
        fail_idx_next = fail_idx_q;
        fail_cnt_next = fail_cnt_q;
        handoff       = 1'b0;

        case (state)
            S_IDLE: begin
                sel_next = '0;
                if (cand_valid && ready_q) begin
                    state_next    = S_EVAL;
                    fail_idx_next = '0;
                    fail_cnt_next = '0;
                end
            end

            S_EVAL: begin
                if (!split_x) begin
                    // Only the first failure records its index, giving the lowest failing split.
                    if (fail_cnt_q == '0) begin
                        fail_idx_next = sel_q;
                    end
                    fail_cnt_next = fail_cnt_q + (SEL_W + 1)'(1);
                end
                if ((!split_x && EARLY_EXIT) || (sel_q == LAST_SEL)) begin
                    state_next = S_DONE;
                end else begin
                    sel_next = sel_q + SEL_W'(1);
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    handoff       = 1'b1;
                    state_next    = S_IDLE;
                    sel_next      = '0;
                    fail_idx_next = '0;
                    fail_cnt_next = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort wins over accept and hand-off; the result and its statistic are discarded.
        if (flush && (state != S_IDLE)) begin
            state_next    = S_IDLE;
            sel_next      = '0;
            fail_idx_next = '0;
            fail_cnt_next = '0;
            handoff       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            fail_idx_q <= '0;
            fail_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            sel_q      <= sel_next;
            fail_idx_q <= fail_idx_next;
            fail_cnt_q <= fail_cnt_next;
            // Registered so ready stays low while reset is held and rises one edge after release.
            ready_q    <= (state_next == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            fail_q <= '0;
        end else if (handoff) begin
            if (result_pass) begin
                if (pass_q != CNT_MAX) begin
                    pass_q <= pass_q + CNT_W'(1);
                end
            end else begin
                if (fail_q != CNT_MAX) begin
                    fail_q <= fail_q + CNT_W'(1);
                end
            end
        end
    end

    assign cand_ready   = ready_q && (state == S_IDLE);
    assign split_sel    = sel_q;
    assign res_valid    = (state == S_DONE);
    assign res_pass     = (state == S_DONE) && result_pass;
    assign res_fail_idx = fail_idx_q;
    assign res_fail_cnt = fail_cnt_q;
    assign busy         = (state != S_IDLE);
    assign stat_pass    = pass_q;
    assign stat_fail    = fail_q;

endmodule

// File: tb/tb_split_check_sequencer.sv
// Directed, table-driven bench: three instances (early-exit, full-scan, 2-bit statistics)
// share clock, reset and handshakes; each gets its own per-split failure mask.
module tb_split_check_sequencer;

    logic clk;
    logic rst_n;
    logic cand_valid;
    logic flush;
    logic res_ready;
    logic [7:0] mask_a, mask_b, mask_c;

    logic       cand_ready_a, split_x_a, res_valid_a, res_pass_a, busy_a;
    logic [2:0] split_sel_a, res_fail_idx_a;
    logic [3:0] res_fail_cnt_a;
    logic [15:0] stat_pass_a, stat_fail_a;

    logic       cand_ready_b, split_x_b, res_valid_b, res_pass_b, busy_b;
    logic [2:0] split_sel_b, res_fail_idx_b;
    logic [3:0] res_fail_cnt_b;
    logic [15:0] stat_pass_b, stat_fail_b;

    logic       cand_ready_c, split_x_c, res_valid_c, res_pass_c, busy_c;
    logic [2:0] split_sel_c, res_fail_idx_c;
    logic [3:0] res_fail_cnt_c;
    logic [1:0] stat_pass_c, stat_fail_c;

    assign split_x_a = ~mask_a[split_sel_a];
    assign split_x_b = ~mask_b[split_sel_b];
    assign split_x_c = ~mask_c[split_sel_c];

    split_check_sequencer #(.NUM_SPLITS(8), .SEL_W(3), .EARLY_EXIT(1'b1), .CNT_W(16)) u_ee (
        .clk(clk), .rst_n(rst_n), .cand_valid(cand_valid), .cand_ready(cand_ready_a),
        .flush(flush), .split_sel(split_sel_a), .split_x(split_x_a), .res_valid(res_valid_a),
        .res_ready(res_ready), .res_pass(res_pass_a), .res_fail_idx(res_fail_idx_a),
        .res_fail_cnt(res_fail_cnt_a), .busy(busy_a), .stat_pass(stat_pass_a),
        .stat_fail(stat_fail_a)
    );

    split_check_sequencer #(.NUM_SPLITS(8), .SEL_W(3), .EARLY_EXIT(1'b0), .CNT_W(16)) u_full (
        .clk(clk), .rst_n(rst_n), .cand_valid(cand_valid), .cand_ready(cand_ready_b),
        .flush(flush), .split_sel(split_sel_b), .split_x(split_x_b), .res_valid(res_valid_b),
        .res_ready(res_ready), .res_pass(res_pass_b), .res_fail_idx(res_fail_idx_b),
        .res_fail_cnt(res_fail_cnt_b), .busy(busy_b), .stat_pass(stat_pass_b),
        .stat_fail(stat_fail_b)
    );

    split_check_sequencer #(.NUM_SPLITS(8), .SEL_W(3), .EARLY_EXIT(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cand_valid(cand_valid), .cand_ready(cand_ready_c),
        .flush(flush), .split_sel(split_sel_c), .split_x(split_x_c), .res_valid(res_valid_c),
        .res_ready(res_ready), .res_pass(res_pass_c), .res_fail_idx(res_fail_idx_c),
        .res_fail_cnt(res_fail_cnt_c), .busy(busy_c), .stat_pass(stat_pass_c),
        .stat_fail(stat_fail_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;     // bit i set = split i returns x=0
        logic       pass;
        int         idx;      // lowest failing index (both instances)
        int         ee_cnt;   // fail count with early exit
        int         ee_lat;   // cycle of res_valid after accept, early exit
        int         full_cnt; // fail count with full scan (latency always 9)
    } vec_t;

    vec_t vecs[6];

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_pass_a, exp_fail_a, exp_pass_b, exp_fail_b, exp_pass_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_pass_a"}, 32'(stat_pass_a), 32'(exp_pass_a));
        check({tag, "_stat_fail_a"}, 32'(stat_fail_a), 32'(exp_fail_a));
        check({tag, "_stat_pass_b"}, 32'(stat_pass_b), 32'(exp_pass_b));
        check({tag, "_stat_fail_b"}, 32'(stat_fail_b), 32'(exp_fail_b));
        check({tag, "_stat_pass_c"}, 32'(stat_pass_c), 32'(exp_pass_c));
        check({tag, "_stat_fail_c"}, 32'(stat_fail_c), 32'd0);
    endtask

    task automatic model_handoff(input logic pass);
        if (pass) begin
            exp_pass_a++;
            exp_pass_b++;
        end else begin
            exp_fail_a++;
            exp_fail_b++;
        end
        if (exp_pass_c < 3) exp_pass_c++;
    endtask

    // One candidate, res_ready high; called at a negedge with all instances idle.
    task automatic run_vec(input vec_t v);
        int   lat_a, lat_b, ia, ib, ca, cb;
        logic pa, pb;
        lat_a = 0; lat_b = 0; ia = 0; ib = 0; ca = 0; cb = 0; pa = 1'bx; pb = 1'bx;
        mask_a = v.mask;
        mask_b = v.mask;
        mask_c = 8'h00;
        res_ready = 1'b1;
        check("ready_idle", 32'(cand_ready_a), 32'd1);
        cand_valid = 1'b1;
        @(negedge clk);
        cand_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c < v.ee_lat) check("sel_step_ee", 32'(split_sel_a), 32'(c - 1));
            if (c < 9) check("sel_step_full", 32'(split_sel_b), 32'(c - 1));
            if (lat_a == 0 && res_valid_a) begin
                lat_a = c; pa = res_pass_a; ia = res_fail_idx_a; ca = res_fail_cnt_a;
            end
            if (lat_b == 0 && res_valid_b) begin
                lat_b = c; pb = res_pass_b; ib = res_fail_idx_b; cb = res_fail_cnt_b;
            end
            @(negedge clk);
        end
        check("lat_ee", 32'(lat_a), 32'(v.ee_lat));
        check("pass_ee", 32'(pa), 32'(v.pass));
        check("idx_ee", 32'(ia), 32'(v.idx));
        check("cnt_ee", 32'(ca), 32'(v.ee_cnt));
        check("lat_full", 32'(lat_b), 32'd9);
        check("pass_full", 32'(pb), 32'(v.pass));
        check("idx_full", 32'(ib), 32'(v.idx));
        check("cnt_full", 32'(cb), 32'(v.full_cnt));
        check("idle_after_ee", 32'(busy_a), 32'd0);
        check("idle_after_full", 32'(busy_b), 32'd0);
        model_handoff(v.pass);
        check_stats("vec");
    endtask

    initial begin
        int waited;
        vecs[0] = '{mask: 8'h00, pass: 1'b1, idx: 0, ee_cnt: 0, ee_lat: 9, full_cnt: 0};
        vecs[1] = '{mask: 8'h08, pass: 1'b0, idx: 3, ee_cnt: 1, ee_lat: 5, full_cnt: 1};
        vecs[2] = '{mask: 8'h64, pass: 1'b0, idx: 2, ee_cnt: 1, ee_lat: 4, full_cnt: 3};
        vecs[3] = '{mask: 8'h01, pass: 1'b0, idx: 0, ee_cnt: 1, ee_lat: 2, full_cnt: 1};
        vecs[4] = '{mask: 8'h80, pass: 1'b0, idx: 7, ee_cnt: 1, ee_lat: 9, full_cnt: 1};
        vecs[5] = '{mask: 8'hFF, pass: 1'b0, idx: 0, ee_cnt: 1, ee_lat: 2, full_cnt: 8};

        exp_pass_a = 0; exp_fail_a = 0; exp_pass_b = 0; exp_fail_b = 0; exp_pass_c = 0;
        rst_n = 1'b0; cand_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
        mask_a = 8'h00; mask_b = 8'h00; mask_c = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(split_sel_a), 32'd0);
        check("rst_res_valid", 32'(res_valid_a), 32'd0);
        check("rst_res_pass", 32'(res_pass_a), 32'd0);
        check("rst_fail_idx", 32'(res_fail_idx_a), 32'd0);
        check("rst_fail_cnt", 32'(res_fail_cnt_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_cand_ready", 32'(cand_ready_a), 32'd0);
        check_stats("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(cand_ready_a), 32'd1);

        // Main table
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-pressure: result held for 10 cycles, no accept while DONE
        mask_a = 8'h08; mask_b = 8'h08; res_ready = 1'b0;
        cand_valid = 1'b1;
        @(negedge clk);
        waited = 0;
        while (!res_valid_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bp_reached_done", 32'(res_valid_a), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(res_valid_a), 32'd1);
            check("bp_pass", 32'(res_pass_a), 32'd0);
            check("bp_idx", 32'(res_fail_idx_a), 32'd3);
            check("bp_cnt", 32'(res_fail_cnt_a), 32'd1);
            check("bp_cand_ready", 32'(cand_ready_a), 32'd0);
            check("bp_stat_hold", 32'(stat_fail_a), 32'(exp_fail_a));
            @(negedge clk);
        end
        check("bp_full_done", 32'(res_valid_b), 32'd1);
        check("bp_full_cnt", 32'(res_fail_cnt_b), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        cand_valid = 1'b0;
        model_handoff(1'b0);
        check("bp_release_idle", 32'(busy_a), 32'd0);
        check("bp_release_valid", 32'(res_valid_a), 32'd0);
        check_stats("bp_release");
        @(negedge clk);
        check_stats("bp_once");

        // Flush at split_sel=4 with cand_valid still high
        mask_a = 8'h00; mask_b = 8'h00; res_ready = 1'b1;
        cand_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("flush_at_sel4", 32'(split_sel_a), 32'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cand_valid = 1'b0;
        check("flush_idle", 32'(busy_a), 32'd0);
        check("flush_idle_full", 32'(busy_b), 32'd0);
        check("flush_valid", 32'(res_valid_a), 32'd0);
        check("flush_sel", 32'(split_sel_a), 32'd0);
        check("flush_ready", 32'(cand_ready_a), 32'd1);
        check_stats("flush");
        run_vec(vecs[0]);

        // Flush while holding a result in DONE: no stat update
        mask_a = 8'h01; mask_b = 8'h01; res_ready = 1'b0;
        cand_valid = 1'b1;
        @(negedge clk);
        cand_valid = 1'b0;
        @(negedge clk);
        check("fdone_valid", 32'(res_valid_a), 32'd1);
        flush = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fdone_idle", 32'(busy_a), 32'd0);
        check("fdone_cnt_clr", 32'(res_fail_cnt_a), 32'd0);
        check_stats("fdone");
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-EVAL
        mask_a = 8'h00; mask_b = 8'h00;
        cand_valid = 1'b1;
        @(negedge clk);
        cand_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_pre_busy", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_sel", 32'(split_sel_a), 32'd0);
        check("arst_valid", 32'(res_valid_a), 32'd0);
        check("arst_cnt", 32'(res_fail_cnt_a), 32'd0);
        check("arst_idx", 32'(res_fail_idx_a), 32'd0);
        exp_pass_a = 0; exp_fail_a = 0; exp_pass_b = 0; exp_fail_b = 0; exp_pass_c = 0;
        check_stats("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready_after", 32'(cand_ready_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
